// File: rtl/exception_controller.sv
// Exception detect/prioritise/redirect controller for the 16-bit datapath.
// Optional sticky cause log is enabled with `define EXC_STICKY_LOG_EN.
module exception_controller #(
    parameter int              INSTR_W       = 16,
    parameter int              ADDR_W        = 16,
    parameter int              NUM_EXT       = 4,
    parameter logic [15:0]     VALID_OP_MASK = 16'h9971,
    parameter logic [ADDR_W-1:0] VECTOR_BASE = 16'h0100,
    parameter int              CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               overflow,
    input  logic               ovf_en,
    input  logic [NUM_EXT-1:0] ext_exc,
    input  logic [NUM_EXT-1:0] ext_mask,
    input  logic               exc_return,
    input  logic               redirect_ready,
    input  logic               log_clr,
    output logic               exception_flag,
    output logic               flush,
    output logic               redirect_valid,
    output logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  epc,
    output logic [3:0]         cause,
    output logic               halted,
    output logic [CNT_W-1:0]   exc_count,
    output logic [NUM_EXT+1:0] exc_log
);

    // Handshake: a redirect transfers on a clock edge where redirect_valid and
    // redirect_ready are both 1; redirect_valid/redirect_addr hold until then.
    typedef enum logic [2:0] {IDLE, FLUSH, VECTOR, HANDLER, HALT} state_t;

    state_t state, state_next;

    logic [3:0]         opcode;
    logic               ill, ovf;
    logic [NUM_EXT-1:0] ext;
    logic [NUM_EXT+1:0] raw;
    logic               any_det;
    logic [3:0]         raw_cause;

    logic               flag_next, flush_next, rv_next, halted_next;
    logic [ADDR_W-1:0]  addr_next, epc_next;
    logic [3:0]         cause_next;
    logic [CNT_W-1:0]   count_next;

    assign opcode  = instr[INSTR_W-1 -: 4];
    assign ill     = instr_valid & ~VALID_OP_MASK[opcode];
    assign ovf     = instr_valid & overflow & ovf_en;
    assign ext     = ext_exc & ext_mask;
    assign raw     = {ext, ovf, ill};
    assign any_det = |raw;

    // Lower-numbered cause wins; scanning ext downwards leaves the lowest index.
    always_comb begin
        raw_cause = 4'd0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (ext[i]) raw_cause = 4'(3 + i);
        end
        if (ovf) raw_cause = 4'd2;
        if (ill) raw_cause = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            exception_flag <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
            epc            <= '0;
            cause          <= 4'd0;
            halted         <= 1'b0;
            exc_count      <= '0;
        end else begin
            state          <= state_next;
            exception_flag <= flag_next;
            flush          <= flush_next;
            redirect_valid <= rv_next;
            redirect_addr  <= addr_next;
            epc            <= epc_next;
            cause          <= cause_next;
            halted         <= halted_next;
            exc_count      <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_det) state_next = FLUSH;
            FLUSH:   state_next = VECTOR;
            VECTOR:  if (redirect_valid && redirect_ready) state_next = HANDLER;
            HANDLER: begin
                if (any_det)         state_next = HALT;
                else if (exc_return) state_next = IDLE;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flag_next   = exception_flag;
        flush_next  = flush;
        rv_next     = redirect_valid;
        addr_next   = redirect_addr;
        epc_next    = epc;
        cause_next  = cause;
        halted_next = halted;
        count_next  = exc_count;
        case (state)
            IDLE: begin
                if (any_det) begin
                    epc_next   = pc;
                    cause_next = raw_cause;
                    flag_next  = 1'b1;
                    flush_next = 1'b1;
                    if (exc_count != '1) count_next = exc_count + CNT_W'(1);
                end
            end
            FLUSH: begin
                flush_next = 1'b0;
                rv_next    = 1'b1;
                addr_next  = VECTOR_BASE + ADDR_W'({cause, 2'b00});
            end
            VECTOR: if (redirect_valid && redirect_ready) rv_next = 1'b0;
            HANDLER: begin
                if (any_det)         halted_next = 1'b1;
                else if (exc_return) flag_next   = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef EXC_STICKY_LOG_EN
    logic unused_instr;
    assign unused_instr = ^instr[INSTR_W-5:0];

    // A detect in the same cycle as log_clr still leaves its bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_log <= '0;
        end else if (state != HALT) begin
            exc_log <= (log_clr ? '0 : exc_log) | raw;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{instr[INSTR_W-5:0], log_clr};
    assign exc_log       = '0;
`endif

endmodule
